// File: rtl/div_scheduler_if.sv
// Requester/result bundle for the two-port shared divider.
// The master side drives requests and operands; the slave side is the divider.
interface div_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] B0;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] B1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             divzero;

    modport master (
        output req0, req1, A0, B0, A1, B1,
        input  ack0, ack1, busy, done, done_id, S, R, divzero
    );

    modport slave (
        input  req0, req1, A0, B0, A1, B1,
        output ack0, ack1, busy, done, done_id, S, R, divzero
    );
endinterface

// File: rtl/div_scheduler.sv
// Two-requester round-robin scheduler around a restoring divider.
// One quotient bit per cycle; divide-by-zero is resolved at capture.
module div_scheduler #(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            reset,
    div_scheduler_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             did_q, did_d;

    logic             any_req;
    logic             grant1;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;
    logic             busy;
    logic             done;

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        grant1  = bus.req1 & (~bus.req0 | ~last_q);
        cap_a   = grant1 ? bus.A1 : bus.A0;
        cap_b   = grant1 ? bus.B1 : bus.B0;
    end

    // One restoring shift-subtract step, dividend bits fed MSB first.
    always_comb begin
        trial     = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        qbit      = (trial >= {1'b0, div_q});
        rem_next  = qbit ? (trial - {1'b0, div_q}) : trial;
        quo_next  = {quo_q[WIDTH-2:0], qbit};
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = (cap_b == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_iter) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next values: capture, iterate, publish result.
    always_comb begin
        quo_d  = quo_q;
        div_d  = div_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        id_d   = id_q;
        last_d = last_q;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        s_d    = s_q;
        r_d    = r_q;
        dz_d   = dz_q;
        did_d  = did_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    quo_d  = cap_a;
                    div_d  = cap_b;
                    rem_d  = '0;
                    cnt_d  = '0;
                    id_d   = grant1;
                    last_d = grant1;
                    ack0_d = ~grant1;
                    ack1_d = grant1;
                    if (cap_b == '0) begin
                        s_d   = '1;
                        r_d   = cap_a;
                        dz_d  = 1'b1;
                        did_d = grant1;
                    end
                end
            end
            RUN: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    cnt_d = '0;
                    s_d   = quo_next;
                    r_d   = rem_next[WIDTH-1:0];
                    dz_d  = 1'b0;
                    did_d = id_q;
                end
            end
            DONE:    ;
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q  <= '0;
            div_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            s_q    <= '0;
            r_q    <= '0;
            dz_q   <= 1'b0;
            did_q  <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            div_q  <= div_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            id_q   <= id_d;
            last_q <= last_d;
            ack0_q <= ack0_d;
            ack1_q <= ack1_d;
            s_q    <= s_d;
            r_q    <= r_d;
            dz_q   <= dz_d;
            did_q  <= did_d;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.done_id = did_q;
    assign bus.S       = s_q;
    assign bus.R       = r_q;
    assign bus.divzero = dz_q;
endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler at WIDTH=4.
// Expected values are hand-computed constants.
module tb_div_scheduler;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;

    div_scheduler_if #(.WIDTH(4)) bus ();

    div_scheduler #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ack0"}, bus.ack0, 0);
        chk({tag, "_ack1"}, bus.ack1, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_did"}, bus.done_id, 0);
        chk({tag, "_S"}, bus.S, 0);
        chk({tag, "_R"}, bus.R, 0);
        chk({tag, "_dz"}, bus.divzero, 0);
    endtask

    // Single request, dropped in its ack cycle; checks latency and result.
    task automatic run_op(input string tag, input bit who,
                          input logic [3:0] a, input logic [3:0] b,
                          input int es, input int er, input bit edz,
                          input int elat);
        int lat;
        if (who) begin
            bus.req1 = 1'b1; bus.A1 = a; bus.B1 = b;
        end else begin
            bus.req0 = 1'b1; bus.A0 = a; bus.B0 = b;
        end
        tick();
        chk({tag, "_ack0"}, bus.ack0, !who);
        chk({tag, "_ack1"}, bus.ack1, who);
        chk({tag, "_busy"}, bus.busy, 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        lat = 1;
        while (!bus.done && lat < 12) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_did"}, bus.done_id, who);
        chk({tag, "_S"}, bus.S, es);
        chk({tag, "_R"}, bus.R, er);
        chk({tag, "_dz"}, bus.divzero, edz);
        tick();
        chk({tag, "_done_off"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_S_hold"}, bus.S, es);
        chk({tag, "_dz_hold"}, bus.divzero, edz);
    endtask

    initial begin
        int pulses;
        int prev;
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        reset    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.A0   = '0;
        bus.B0   = '0;
        bus.A1   = '0;
        bus.B1   = '0;

        // Reset state, and requests ignored while in reset.
        tick();
        chk_idle_outs("rst");
        bus.req0 = 1'b1; bus.A0 = 4'd5; bus.B0 = 4'd1;
        tick();
        chk("rst_noreq_busy", bus.busy, 0);
        chk("rst_noreq_ack", bus.ack0, 0);
        bus.req0 = 1'b0;
        reset = 1'b1;
        tick();
        chk_idle_outs("post_rst");

        // 13/3 and 7/0.
        run_op("d13_3", 1'b0, 4'd13, 4'd3, 4, 1, 1'b0, 5);
        run_op("d7_0", 1'b1, 4'd7, 4'd0, 15, 7, 1'b1, 1);

        // Asynchronous reset between edges clears outputs at once.
        reset = 1'b0;
        #2;
        chk("async_S", bus.S, 0);
        chk("async_dz", bus.divzero, 0);
        reset = 1'b1;

        // Tie after reset: req0 first, req1 follows.
        bus.req0 = 1'b1; bus.A0 = 4'd9;  bus.B0 = 4'd2;
        bus.req1 = 1'b1; bus.A1 = 4'd15; bus.B1 = 4'd4;
        tick();
        chk("tie_ack0", bus.ack0, 1);
        chk("tie_ack1", bus.ack1, 0);
        bus.req0 = 1'b0;
        bus.A0 = 4'd1; bus.B0 = 4'd1;
        repeat (3) tick();
        chk("tie_nodone", bus.done, 0);
        tick();
        chk("tie0_done", bus.done, 1);
        chk("tie0_did", bus.done_id, 0);
        chk("tie0_S", bus.S, 4);
        chk("tie0_R", bus.R, 1);
        tick();
        chk("tie_gap_busy", bus.busy, 0);
        chk("tie_gap_ack1", bus.ack1, 0);
        tick();
        chk("tie1_ack1", bus.ack1, 1);
        chk("tie1_ack0", bus.ack0, 0);
        bus.req1 = 1'b0;
        repeat (4) tick();
        chk("tie1_done", bus.done, 1);
        chk("tie1_did", bus.done_id, 1);
        chk("tie1_S", bus.S, 3);
        chk("tie1_R", bus.R, 3);
        tick();

        // Both held high: alternating owners, six cycles apart.
        bus.req0 = 1'b1; bus.A0 = 4'd13; bus.B0 = 4'd3;
        bus.req1 = 1'b1; bus.A1 = 4'd15; bus.B1 = 4'd4;
        pulses = 0;
        prev   = 0;
        for (int n = 0; n < 60 && pulses < 4; n++) begin
            tick();
            if (bus.done) begin
                chk($sformatf("rr%0d_did", pulses), bus.done_id, pulses % 2);
                chk($sformatf("rr%0d_S", pulses), bus.S,
                    (pulses % 2) ? 3 : 4);
                chk($sformatf("rr%0d_R", pulses), bus.R,
                    (pulses % 2) ? 3 : 1);
                if (pulses > 0)
                    chk($sformatf("rr%0d_gap", pulses), cyc - prev, 6);
                prev = cyc;
                pulses++;
            end
        end
        chk("rr_pulses", pulses, 4);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (8) tick();
        chk("rr_drain", bus.busy, 0);

        // Boundaries: quotient zero and divisor one.
        run_op("d2_5", 1'b0, 4'd2, 4'd5, 0, 2, 1'b0, 5);
        run_op("d15_1", 1'b0, 4'd15, 4'd1, 15, 0, 1'b0, 5);

        // Reset on the second RUN cycle abandons the operation.
        bus.req0 = 1'b1; bus.A0 = 4'd13; bus.B0 = 4'd3;
        tick();
        chk("ab_ack0", bus.ack0, 1);
        tick();
        chk("ab_run", bus.busy, 1);
        reset = 1'b0;
        #1;
        chk_idle_outs("ab_rst");
        tick();
        chk("ab_hold_busy", bus.busy, 0);
        chk("ab_hold_done", bus.done, 0);
        reset = 1'b1;
        run_op("ab_retry", 1'b0, 4'd13, 4'd3, 4, 1, 1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand, quotient and remainder width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset; low forces the reset state immediately, independent of clk.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each, the per-requester request, held high until the matching ack.
REQ-005 The block SHALL have ports A0, B0, A1 and B1, input, WIDTH each, the dividend and divisor of requester 0 and requester 1, stable while the matching req is high.
REQ-006 The block SHALL have ports ack0 and ack1, output, 1 each, a one-cycle pulse confirming that the operands were captured.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have ports done (output, 1) and done_id (output, 1): a one-cycle result-valid pulse, and the requester that owns the result.
REQ-009 The block SHALL have ports S (output, WIDTH), the quotient, and R (output, WIDTH), the remainder.
REQ-010 The block SHALL have port divzero, output, 1, set for a result whose divisor was 0.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-012 In IDLE, on a clk edge with any req high, the block SHALL capture the granted requester's A and B, record its id and leave IDLE.
- Next state: RUN if B != 0; DONE if B == 0.
REQ-013 Arbitration SHALL be round-robin on a last-served pointer.
- Only one req high: that requester wins.
- Both high: the requester not last served wins.
- Pointer reset value: 1, so req0 wins the first tie.
REQ-014 The matching ack SHALL be high for exactly the one cycle following the capture edge; the other ack SHALL stay low.
REQ-015 RUN SHALL perform restoring shift-subtract division, one quotient bit per clk edge, MSB first.
- Partial remainder: WIDTH+1 bits.
- RUN lasts exactly WIDTH edges, counted by an internal iteration counter.
- After the last edge the state SHALL be DONE.
REQ-016 On entry to DONE the block SHALL register S and R.
- S = floor(A/B), R = A mod B, both unsigned.
- done SHALL be high for exactly the one DONE cycle.
- DONE SHALL always go to IDLE on the next edge.
REQ-017 Latency from the capture edge to the done cycle SHALL be WIDTH+1 cycles for B != 0 and 1 cycle for B == 0.
REQ-018 For B == 0 the result SHALL be S = all ones, R = A, divzero = 1; the ack and done cycles then coincide.
REQ-019 S, R, divzero and done_id SHALL hold their last values until the next DONE; divzero SHALL be 0 for any result with B != 0.
REQ-020 A req still high in IDLE SHALL start a new operation; a requester wanting no further operation SHALL deassert req in its ack cycle.
REQ-021 Requests arriving during RUN or DONE SHALL be ignored until IDLE; operand changes after capture SHALL not affect the result in flight.
REQ-022 Peak throughput SHALL be one operation per WIDTH+2 cycles.

Reset
REQ-023 While reset is low the block SHALL hold: state IDLE, busy 0, ack0 0, ack1 0, done 0, done_id 0, S 0, R 0, divzero 0, last-served pointer 1, iteration counter 0.
REQ-024 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation without a done pulse; after release, a requester still requesting is re-arbitrated from IDLE.

Verification (WIDTH = 4)
REQ-025 req0, A0=13, B0=3 -> ack0 one cycle after capture; done at capture+5, done_id=0, S=4, R=1, divzero=0.
REQ-026 req1, A1=7, B1=0 -> ack1 and done in the same cycle, one cycle after capture; S=15, R=7, divzero=1.
REQ-027 req0 (9/2) and req1 (15/4) both high after reset, each held until its ack -> req0 served first (S=4, R=1, done_id=0), then req1 (S=3, R=3, done_id=1).
REQ-028 req0 and req1 held permanently high -> done_id alternates 0,1,0,1 with done pulses WIDTH+2=6 cycles apart.
REQ-029 req0, A0=2, B0=5 -> S=0, R=2; A0=15, B0=1 -> S=15, R=0.
REQ-030 reset pulsed low on the 2nd RUN cycle of 13/3 -> all outputs zero immediately, no done; after release with req0 still high, operation restarts and yields S=4, R=1.
